bsg_comm_link_credit_tx: RTL and testbench

BSG_COMM_LINK_CREDIT_TX -- requirements
Module: bsg_comm_link_credit_tx

---
 rtl/bsg_comm_link_pkg.sv | 20 ++
 rtl/bsg_sync_sync.sv | 29 ++
 rtl/bsg_comm_link_credit_tx.sv | 148 ++++++++++++++
 tb/tb_bsg_comm_link_credit_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_comm_link_pkg.sv
// Package for the credit-based comm-link transmitter. It holds:
//   - credit_width(): the width of a credit counter that can hold the value 2^lg_depth
//   - the default far-end FIFO depth and token decimation constants
//   - the alternating idle patterns, 256 bits wide; users truncate them to
//     their channel width
package bsg_comm_link_pkg;

  localparam int lg_input_fifo_depth_default_lp           = 5;
  localparam int lg_credit_to_token_decimation_default_lp = 3;

  // Idle patterns, LSB first: even = ...0101b, odd = ...1010b.
  localparam logic [255:0] idle_pattern_even_lp = {128{2'b01}};
  localparam logic [255:0] idle_pattern_odd_lp  = {128{2'b10}};

  // A counter that reaches 2^lg_depth needs lg_depth+1 bits.
  function automatic int credit_width(input int lg_depth);
    return lg_depth + 1;
  endfunction

endpackage

// File: rtl/bsg_sync_sync.sv
// Two-flop synchronizer for bringing an asynchronous level into clk_i.
// Ports:
//   clk_i   - destination clock
//   reset_i - asynchronous active-high reset; clears both stages
//   data_i  - asynchronous input level(s)
//   data_o  - synchronized level(s), two destination edges later
module bsg_sync_sync #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] sync_1_r;

  // metastability-settling chain: capture stage then output stage
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_1_r <= {width_p{1'b0}};
      data_o   <= {width_p{1'b0}};
    end else begin
      sync_1_r <= data_i;
      data_o   <= sync_1_r;
    end
  end

endmodule

// File: rtl/bsg_comm_link_credit_tx.sv
// Credit-based transmitter for one comm-link channel.
// Words are accepted while credits remain. Each accepted word is launched on
// the channel one cycle later. The far end returns credits in batches of
// 2^lg_credit_to_token_decimation_p, signalled by toggling token_toggle_i.
//
// Optional feature: define BSG_COMM_LINK_CREDIT_TX_IDLE_PATTERN_EN to drive an
// alternating 0101../1010.. pattern on data_o during idle cycles. When the
// macro is undefined, data_o holds the last word sent.
//
// Ports:
//   clk_i          - clock
//   reset_i        - asynchronous active-high reset
//   valid_i/data_i - offered word
//   ready_o        - a word can be accepted (credits nonzero)
//   token_toggle_i - asynchronous; each transition returns one token
//   valid_o/data_o - registered channel outputs
//   credits_o      - current credit count
//   error_o        - sticky credit-overflow flag
module bsg_comm_link_credit_tx
  import bsg_comm_link_pkg::*;
#(
  parameter channel_width_p                     = "inv",
  parameter int lg_input_fifo_depth_p           = lg_input_fifo_depth_default_lp,
  parameter int lg_credit_to_token_decimation_p = lg_credit_to_token_decimation_default_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic [channel_width_p-1:0]   data_i,
  output logic                         ready_o,
  input  logic                         token_toggle_i,
  output logic                         valid_o,
  output logic [channel_width_p-1:0]   data_o,
  output logic [lg_input_fifo_depth_p:0] credits_o,
  output logic                         error_o
);

  localparam int cw_lp = credit_width(lg_input_fifo_depth_p);

  // Sums are computed one bit wider than the counter so that overflow is visible.
  localparam logic [cw_lp:0] max_credits_lp = (cw_lp+1)'(1) << lg_input_fifo_depth_p;
  localparam logic [cw_lp:0] token_inc_lp   = (cw_lp+1)'(1) << lg_credit_to_token_decimation_p;

  logic [cw_lp-1:0]           credits_r;
  logic [cw_lp-1:0]           credits_next_s;
  logic [cw_lp:0]             credit_sum_s;
  logic                       overflow_s;
  logic                       transfer_s;
  logic                       token_sync_s;
  logic                       token_last_r;
  logic                       token_pulse_s;
  logic [channel_width_p-1:0] data_next_s;

  assign ready_o   = (credits_r != {cw_lp{1'b0}});
  assign credits_o = credits_r;

  bsg_sync_sync #(
    .width_p (1)
  ) token_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (token_toggle_i),
    .data_o  (token_sync_s)
  );

  // Each edge of the synchronized toggle is one token.
  assign token_pulse_s = token_sync_s ^ token_last_r;

  // Credit arithmetic: a transfer and a token in the same cycle net together.
  always_comb begin
    transfer_s     = valid_i & ready_o;
    credit_sum_s   = {1'b0, credits_r}
                   - {{cw_lp{1'b0}}, transfer_s}
                   + (token_pulse_s ? token_inc_lp : {(cw_lp+1){1'b0}});
    credits_next_s = credits_r;
    overflow_s     = 1'b0;
    if (credit_sum_s > max_credits_lp) begin
      credits_next_s = max_credits_lp[cw_lp-1:0];
      overflow_s     = 1'b1;
    end else begin
      credits_next_s = credit_sum_s[cw_lp-1:0];
      overflow_s     = 1'b0;
    end
  end

  // Credit counter, token edge detector and sticky overflow flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r    <= max_credits_lp[cw_lp-1:0];
      token_last_r <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      credits_r    <= credits_next_s;
      token_last_r <= token_sync_s;
      error_o      <= error_o | overflow_s;
    end
  end

`ifdef BSG_COMM_LINK_CREDIT_TX_IDLE_PATTERN_EN
  // 0 selects ...0101b for the next idle cycle; restarts after every transfer.
  logic idle_phase_r;

  // Idle pattern phase: flips every idle cycle, cleared by a transfer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_phase_r <= 1'b0;
    end else if (transfer_s) begin
      idle_phase_r <= 1'b0;
    end else begin
      idle_phase_r <= ~idle_phase_r;
    end
  end

  // Next channel data: the word on a transfer, otherwise the idle pattern.
  always_comb begin
    data_next_s = data_o;
    if (transfer_s) begin
      data_next_s = data_i;
    end else if (idle_phase_r) begin
      data_next_s = channel_width_p'(idle_pattern_odd_lp);
    end else begin
      data_next_s = channel_width_p'(idle_pattern_even_lp);
    end
  end
`else
  // Next channel data: the word on a transfer, otherwise hold the last value.
  always_comb begin
    data_next_s = data_o;
    if (transfer_s) begin
      data_next_s = data_i;
    end else begin
      data_next_s = data_o;
    end
  end
`endif

  // Registered channel outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= {channel_width_p{1'b0}};
    end else begin
      valid_o <= transfer_s;
      data_o  <= data_next_s;
    end
  end

endmodule

// File: tb/tb_bsg_comm_link_credit_tx.sv
module tb_bsg_comm_link_credit_tx;

  localparam int W   = 16;
  localparam int LG  = 5;
  localparam int DEC = 3;
  localparam int CAP = 32;
  localparam int INC = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  data_i;
  logic          ready_o;
  logic          token_toggle_i;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic [LG:0]   credits_o;
  logic          error_o;

  bsg_comm_link_credit_tx #(
    .channel_width_p                 (W),
    .lg_input_fifo_depth_p           (LG),
    .lg_credit_to_token_decimation_p (DEC)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .token_toggle_i (token_toggle_i),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .credits_o      (credits_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: words expected on the channel, and the edges at which tokens land.
  logic [W-1:0] sb_q[$];
  int           tok_q[$];

  int           cyc = 0;
  int           last_tog_cyc = -100;
  int           model_credits;
  int           model_error;
  int           idle_k;
  logic [W-1:0] last_data;
  logic [W-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the channel against the scoreboard each cycle.
  always @(posedge clk) begin
    #1;
    if (!reset_i) begin
      if (sb_q.size() > 0) begin
        mon_exp = sb_q.pop_front();
        chk("valid_o on word", {31'd0, valid_o}, 32'd1);
        chk("data_o word", {16'd0, data_o}, {16'd0, mon_exp});
        last_data = mon_exp;
        idle_k    = 0;
      end else begin
        chk("valid_o idle", {31'd0, valid_o}, 32'd0);
`ifdef BSG_COMM_LINK_CREDIT_TX_IDLE_PATTERN_EN
        mon_exp = (idle_k % 2 == 0) ? 16'h5555 : 16'hAAAA;
        idle_k++;
`else
        mon_exp = last_data;
`endif
        chk("data_o idle", {16'd0, data_o}, {16'd0, mon_exp});
      end
    end
  end

  // One clock: drive inputs, advance the reference model, check credit state.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit tog);
    bit xfer;
    valid_i = v;
    data_i  = d;
    xfer    = v && (model_credits != 0);
    if (xfer) sb_q.push_back(d);
    if (tog) begin
      token_toggle_i = ~token_toggle_i;
      tok_q.push_back(cyc + 3);
      last_tog_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    model_credits = model_credits - (xfer ? 1 : 0);
    if (tok_q.size() > 0 && tok_q[0] == cyc) begin
      void'(tok_q.pop_front());
      model_credits = model_credits + INC;
    end
    if (model_credits > CAP) begin
      model_credits = CAP;
      model_error   = 1;
    end
    #1;
    chk("credits_o", {26'd0, credits_o}, model_credits);
    chk("ready_o", {31'd0, ready_o}, (model_credits != 0) ? 32'd1 : 32'd0);
    chk("error_o", {31'd0, error_o}, model_error);
    #1;
  endtask

  task automatic do_reset();
    valid_i        = 1'b0;
    data_i         = '0;
    token_toggle_i = 1'b0;
    reset_i        = 1'b1;
    sb_q.delete();
    tok_q.delete();
    #1;
    chk("reset credits_o", {26'd0, credits_o}, CAP);
    chk("reset ready_o", {31'd0, ready_o}, 32'd1);
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset data_o", {16'd0, data_o}, 32'd0);
    chk("reset error_o", {31'd0, error_o}, 32'd0);
    model_credits = CAP;
    model_error   = 0;
    last_data     = '0;
    idle_k        = 0;
    @(posedge clk);
    #2;
    reset_i      = 1'b0;
    last_tog_cyc = cyc - 100;
  endtask

  initial begin
    bit v;
    bit tog;
    reset_i        = 1'b1;
    valid_i        = 1'b0;
    data_i         = '0;
    token_toggle_i = 1'b0;
    model_credits  = CAP;
    model_error    = 0;
    last_data      = '0;
    idle_k         = 0;

    do_reset();

    // 32 back-to-back words drain all credits; the 33rd offer is refused.
    for (int i = 1; i <= 32; i++) cycle(1'b1, W'(i), 1'b0);
    chk("credits after 32 words", {26'd0, credits_o}, 32'd0);
    cycle(1'b1, 16'h0033, 1'b0);
    chk("ready_o at zero credits", {31'd0, ready_o}, 32'd0);

    // One token at zero credits lands exactly two edges after it is captured.
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("credits before token lands", {26'd0, credits_o}, 32'd0);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("credits after one token", {26'd0, credits_o}, 32'd8);

    // Down to 5, then a transfer and a token on the same edge.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0);
    chk("credits at 5", {26'd0, credits_o}, 32'd5);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 16'h0BEE, 1'b0);
    chk("credits transfer+token", {26'd0, credits_o}, 32'd12);

    // Overflow from 30 saturates at 32 and sets a sticky error.
    do_reset();
    cycle(1'b1, 16'h0A01, 1'b0);
    cycle(1'b1, 16'h0A02, 1'b0);
    chk("credits at 30", {26'd0, credits_o}, 32'd30);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("credits saturated", {26'd0, credits_o}, 32'd32);
    chk("error set on overflow", {31'd0, error_o}, 32'd1);
    for (int i = 0; i < 100; i++) cycle(1'b0, 16'h0000, 1'b0);
    chk("error sticky", {31'd0, error_o}, 32'd1);
    do_reset();

    // A word followed by idle cycles (pattern or hold, depending on build).
    cycle(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b0);

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      v   = ($urandom_range(0, 9) < 7);
      tog = ((cyc - last_tog_cyc) >= 2) && ($urandom_range(0, 11) == 0);
      cycle(v, W'($urandom), tog);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b0);
    chk("scoreboard drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
